// File: rtl/mode_pkg.sv
// Shared mode encodings for the key sequencer, mode muxes and HEX5 display.
// Also holds the default debounce period for a 50 MHz system clock.
package mode_pkg;

  typedef enum logic [1:0] {
    MODE_ARITH   = 2'd0,
    MODE_LOGIC   = 2'd1,
    MODE_COMPARE = 2'd2,
    MODE_MAGIC   = 2'd3
  } mode_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  function automatic mode_t mode_step(
    input mode_t m,
    input logic  up
  );
    return up ? mode_t'(m + 2'd1) : mode_t'(m - 2'd1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push button: 2-flop synchroniser, stable-count debouncer, press edge.
// Output level is active-high; the press pulse fires on released->pressed.
module key_debounce
  import mode_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_d;
  logic          r_press;
  logic          w_s;
  logic          w_diff;
  logic          w_done;

  assign w_s    = ~r_sync[1];
  assign w_diff = w_s != r_d;
  assign w_done = w_diff && (r_cnt == LAST);

  // Bring the raw key into the clock domain; reset reads as released.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], i_key_n};
  end

  // Count stable disagreement; accept the new level after the full period.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt   <= '0;
      r_d     <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= w_done & ~r_d;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt <= '0;
        r_d   <= ~r_d;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_d;
  assign o_press = r_press;

endmodule

// File: rtl/mode_key_sequencer.sv
// Debounced KEY[0]/KEY[1] step a registered 2-bit MODE up/down with wrap.
// MODE_STB pulses in exactly the cycles where MODE changes.
module mode_key_sequencer
  import mode_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] KEY,
  output logic [1:0] MODE,
  output logic       MODE_STB,
  output logic [1:0] KEY_PRESSED
);

  logic [1:0] w_level;
  logic [1:0] w_press;
  mode_t      r_mode;
  logic       r_stb;

  for (genvar i = 0; i < 2; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .CLK    (CLK),
      .RST    (RST),
      .i_key_n(KEY[i]),
      .o_level(w_level[i]),
      .o_press(w_press[i])
    );
  end

  // Single press steps the mode; simultaneous presses cancel out.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mode <= MODE_ARITH;
      r_stb  <= 1'b0;
    end else begin
      r_stb <= w_press[0] ^ w_press[1];
      if (w_press[0] ^ w_press[1])
        r_mode <= mode_step(r_mode, w_press[0]);
    end
  end

  assign MODE        = r_mode;
  assign MODE_STB    = r_stb;
  assign KEY_PRESSED = w_level;

endmodule
